// File: rtl/rtc_calendar_core_if.sv
// Purpose: board-side bundle for the RTC core (buttons, page switch, display page, status).
// Latency: n/a (wiring only).
// Backpressure: none; all signals are levels or single-cycle pulses.
// Ports: sw_mode, butt_increase, butt_decrease, butt_change (board -> core);
//        disp_bcd[31:0], edit_field[2:0], tick_1s (core -> board/decoders).
interface rtc_calendar_core_if;
    logic        sw_mode;
    logic        butt_increase;
    logic        butt_decrease;
    logic        butt_change;
    logic [31:0] disp_bcd;
    logic [2:0]  edit_field;
    logic        tick_1s;

    // board / button side
    modport master (
        output sw_mode, butt_increase, butt_decrease, butt_change,
        input  disp_bcd, edit_field, tick_1s
    );

    // RTC core side
    modport slave (
        input  sw_mode, butt_increase, butt_decrease, butt_change,
        output disp_bcd, edit_field, tick_1s
    );
endinterface

// File: rtl/rtc_calendar_core.sv
// Purpose: BCD clock/calendar with Gregorian leap rules, button field editing and blinking display page.
// Latency: button edge acts 3 clocks after it is applied; disp_bcd lags state by 1 clock.
// Backpressure: none; buttons are level inputs, display is refreshed every clock.
// Ports: clk, rst_n (async active-low); bus = rtc_calendar_core_if.slave
//        (sw_mode, butt_* in; disp_bcd, edit_field, tick_1s out).
module rtc_calendar_core #(
    parameter int          TICK_COUNT  = 50_000_000,
    parameter int          BLINK_COUNT = 12_500_000,
    parameter logic [15:0] RESET_YEAR  = 16'h2024,
    parameter int          CNT_W       = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    rtc_calendar_core_if.slave bus
);

    localparam logic [CNT_W-1:0] TICK_MAX  = CNT_W'(TICK_COUNT - 1);
    localparam logic [CNT_W-1:0] BLINK_MAX = CNT_W'(BLINK_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        F_RUN   = 3'd0,
        F_HOUR  = 3'd1,
        F_MIN   = 3'd2,
        F_DAY   = 3'd3,
        F_MONTH = 3'd4,
        F_YEAR  = 3'd5
    } field_t;

    // ---------------- BCD helpers ----------------
    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec8(input logic [7:0] v);
        return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
        if (v == 16'h9999)      return 16'h0000;
        else if (v[7:0] == 8'h99) return {bcd_inc8(v[15:8]), 8'h00};
        else                    return {v[15:8], bcd_inc8(v[7:0])};
    endfunction

    function automatic logic [15:0] bcd_dec16(input logic [15:0] v);
        if (v == 16'h0000)      return 16'h9999;
        else if (v[7:0] == 8'h00) return {bcd_dec8(v[15:8]), 8'h99};
        else                    return {v[15:8], bcd_dec8(v[7:0])};
    endfunction

    // Two BCD digits divisible by 4: v[4] is the parity of the tens digit.
    function automatic logic bcd_div4(input logic [7:0] v);
        if (v[4]) return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
        else      return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
    endfunction

    // Century years are leap only when the century number itself divides by 4.
    function automatic logic is_leap(input logic [15:0] y);
        return (y[7:0] == 8'h00) ? bcd_div4(y[15:8]) : bcd_div4(y[7:0]);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [15:0] y);
        case (m)
            8'h02:                      return is_leap(y) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    // ---------------- state ----------------
    logic [2:0]       btn_s1, btn_s2, btn_prev;   // {change, decrease, increase}
    logic [CNT_W-1:0] presc;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_on;
    field_t           field;
    logic [7:0]       second, minute, hour, day, month;
    logic [15:0]      year;
    logic [31:0]      disp;

    logic [2:0]       evt;
    logic             inc_evt, dec_evt, chg_evt, inc_op, dec_op, tick;
    logic [7:0]       second_n, minute_n, hour_n, day_n, month_n;
    logic [15:0]      year_n;
    logic [7:0]       dim_cur;
    logic             cal_page;
    logic [31:0]      disp_n;

    assign evt     = btn_s2 & ~btn_prev;
    assign inc_evt = evt[0];
    assign dec_evt = evt[1];
    assign chg_evt = evt[2];
    // change wins over inc/dec; inc together with dec cancels
    assign inc_op  = inc_evt & ~dec_evt & ~chg_evt;
    assign dec_op  = dec_evt & ~inc_evt & ~chg_evt;
    assign tick    = (field == F_RUN) && (presc == TICK_MAX);
    assign dim_cur = days_in_month(month, year);

    // ---------------- next calendar state ----------------
    always_comb begin
        second_n = second;
        minute_n = minute;
        hour_n   = hour;
        day_n    = day;
        month_n  = month;
        year_n   = year;
        case (field)
            F_RUN: begin
                // whole carry chain settles in one clock, so no out-of-range digit is stored
                if (tick) begin
                    if (second != 8'h59) second_n = bcd_inc8(second);
                    else begin
                        second_n = 8'h00;
                        if (minute != 8'h59) minute_n = bcd_inc8(minute);
                        else begin
                            minute_n = 8'h00;
                            if (hour != 8'h23) hour_n = bcd_inc8(hour);
                            else begin
                                hour_n = 8'h00;
                                if (day < dim_cur) day_n = bcd_inc8(day);
                                else begin
                                    day_n = 8'h01;
                                    if (month != 8'h12) month_n = bcd_inc8(month);
                                    else begin
                                        month_n = 8'h01;
                                        year_n  = bcd_inc16(year);
                                    end
                                end
                            end
                        end
                    end
                end
            end
            F_HOUR: begin
                if (inc_op)      hour_n = (hour == 8'h23) ? 8'h00 : bcd_inc8(hour);
                else if (dec_op) hour_n = (hour == 8'h00) ? 8'h23 : bcd_dec8(hour);
            end
            F_MIN: begin
                if (inc_op)      minute_n = (minute == 8'h59) ? 8'h00 : bcd_inc8(minute);
                else if (dec_op) minute_n = (minute == 8'h00) ? 8'h59 : bcd_dec8(minute);
            end
            F_DAY: begin
                if (inc_op)      day_n = (day >= dim_cur) ? 8'h01 : bcd_inc8(day);
                else if (dec_op) day_n = (day <= 8'h01) ? dim_cur : bcd_dec8(day);
            end
            F_MONTH: begin
                if (inc_op)      month_n = (month == 8'h12) ? 8'h01 : bcd_inc8(month);
                else if (dec_op) month_n = (month == 8'h01) ? 8'h12 : bcd_dec8(month);
                if (day > days_in_month(month_n, year)) day_n = days_in_month(month_n, year);
            end
            F_YEAR: begin
                if (inc_op)      year_n = bcd_inc16(year);
                else if (dec_op) year_n = bcd_dec16(year);
                if (day > days_in_month(month, year_n)) day_n = days_in_month(month, year_n);
                // leaving edit restarts the second from zero
                if (chg_evt) second_n = 8'h00;
            end
            default: ;
        endcase
    end

    // ---------------- display page ----------------
    always_comb begin
        cal_page = (field == F_RUN) ? bus.sw_mode
                                    : (field == F_DAY || field == F_MONTH || field == F_YEAR);
        if (cal_page)
            disp_n = {(field == F_DAY   && !blink_on) ? 8'hFF    : day,
                      (field == F_MONTH && !blink_on) ? 8'hFF    : month,
                      (field == F_YEAR  && !blink_on) ? 16'hFFFF : year};
        else
            disp_n = {(field == F_HOUR && !blink_on) ? 8'hFF : hour,
                      (field == F_MIN  && !blink_on) ? 8'hFF : minute,
                      second, 8'hFF};
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1    <= '0;
            btn_s2    <= '0;
            btn_prev  <= '0;
            presc     <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            field     <= F_RUN;
            second    <= 8'h00;
            minute    <= 8'h00;
            hour      <= 8'h00;
            day       <= 8'h01;
            month     <= 8'h01;
            year      <= RESET_YEAR;
            disp      <= 32'h0000_00FF;
        end else begin
            btn_s1   <= {bus.butt_change, bus.butt_decrease, bus.butt_increase};
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;

            second <= second_n;
            minute <= minute_n;
            hour   <= hour_n;
            day    <= day_n;
            month  <= month_n;
            year   <= year_n;

            // prescaler is held at zero while editing, so exit restarts a full second
            if (field != F_RUN || chg_evt) presc <= '0;
            else if (presc == TICK_MAX)    presc <= '0;
            else                           presc <= presc + CNT_ONE;

            // every field change restarts the blink in the visible phase
            if (field == F_RUN || chg_evt) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (blink_cnt == BLINK_MAX) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + CNT_ONE;
            end

            if (chg_evt) begin
                case (field)
                    F_RUN:   field <= F_HOUR;
                    F_HOUR:  field <= F_MIN;
                    F_MIN:   field <= F_DAY;
                    F_DAY:   field <= F_MONTH;
                    F_MONTH: field <= F_YEAR;
                    default: field <= F_RUN;
                endcase
            end

            disp <= disp_n;
        end
    end

    assign bus.disp_bcd   = disp;
    assign bus.edit_field = field;
    assign bus.tick_1s    = tick;

endmodule
